// File: rtl/rollback_controller.sv
// Per-thread rollback arbiter: resolves trap / dcache / execute rollback requests by
// pipeline age, registers one command per thread, and masks wrong-path requests after it.
`ifndef THREADS_PER_CORE
`define THREADS_PER_CORE 4
`endif

module rollback_controller #(
    parameter int NUM_THREADS   = `THREADS_PER_CORE,
    parameter int SQUASH_CYCLES = 2,
    localparam int TW = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wb_trap_en,
    input  logic [TW-1:0]              wb_trap_thread_idx,
    input  logic [31:0]                wb_trap_pc,
    input  logic                       dd_rollback_en,
    input  logic [TW-1:0]              dd_rollback_thread_idx,
    input  logic [31:0]                dd_rollback_pc,
    input  logic                       ix_rollback_en,
    input  logic [TW-1:0]              ix_thread_idx,
    input  logic [31:0]                ix_rollback_pc,
    input  logic [3:0]                 ix_subcycle,
    output logic [NUM_THREADS-1:0]     rb_rollback_en,
    output logic [NUM_THREADS*32-1:0]  rb_rollback_pc,
    output logic [NUM_THREADS*4-1:0]   rb_rollback_subcycle,
    output logic [NUM_THREADS*2-1:0]   rb_rollback_source,
    output logic [NUM_THREADS-1:0]     rb_squash_active,
    output logic                       rb_perf_rollback,
    output logic                       rb_perf_suppressed
);
    // A zero-length window still needs a one-bit counter that simply never leaves 0.
    localparam int CW = (SQUASH_CYCLES > 0) ? $clog2(SQUASH_CYCLES + 1) : 1;

    localparam logic [1:0] SRC_NONE = 2'd0;
    localparam logic [1:0] SRC_IX   = 2'd1;
    localparam logic [1:0] SRC_DD   = 2'd2;
    localparam logic [1:0] SRC_TRAP = 2'd3;

    logic [CW-1:0]             squash_cnt    [NUM_THREADS];
    logic [CW-1:0]             squash_cnt_nx [NUM_THREADS];
    logic [NUM_THREADS-1:0]    trap_hit, dd_hit, ix_hit, busy;
    logic [NUM_THREADS-1:0]    en_nx;
    logic [NUM_THREADS*32-1:0] pc_nx;
    logic [NUM_THREADS*4-1:0]  sub_nx;
    logic [NUM_THREADS*2-1:0]  src_nx;
    logic                      suppressed_nx;

    // NOTE: every combinational output is given a default before the loop so no path
    // through the block leaves a variable unassigned and infers a latch.
    always_comb begin
        trap_hit         = '0;
        dd_hit           = '0;
        ix_hit           = '0;
        busy             = '0;
        rb_squash_active = '0;
        for (int t = 0; t < NUM_THREADS; t++) begin
            trap_hit[t]         = wb_trap_en && (wb_trap_thread_idx == TW'(t));
            dd_hit[t]           = dd_rollback_en && (dd_rollback_thread_idx == TW'(t));
            ix_hit[t]           = ix_rollback_en && (ix_thread_idx == TW'(t));
            busy[t]             = (squash_cnt[t] != '0);
            rb_squash_active[t] = busy[t];
        end
    end

    // Winner per thread: trap always, otherwise dd then ix unless the window masks them.
    always_comb begin
        en_nx         = '0;
        src_nx        = '0;
        pc_nx         = rb_rollback_pc;
        sub_nx        = rb_rollback_subcycle;
        suppressed_nx = 1'b0;
        for (int t = 0; t < NUM_THREADS; t++) begin
            squash_cnt_nx[t] = busy[t] ? squash_cnt[t] - 1'b1 : '0;
            if (busy[t] && (dd_hit[t] || ix_hit[t]))
                suppressed_nx = 1'b1;
            if (trap_hit[t]) begin
                en_nx[t]           = 1'b1;
                src_nx[t*2 +: 2]   = SRC_TRAP;
                pc_nx[t*32 +: 32]  = wb_trap_pc;
                sub_nx[t*4 +: 4]   = 4'd0;
            end else if (dd_hit[t] && !busy[t]) begin
                en_nx[t]           = 1'b1;
                src_nx[t*2 +: 2]   = SRC_DD;
                pc_nx[t*32 +: 32]  = dd_rollback_pc;
                sub_nx[t*4 +: 4]   = 4'd0;
            end else if (ix_hit[t] && !busy[t]) begin
                en_nx[t]           = 1'b1;
                src_nx[t*2 +: 2]   = SRC_IX;
                pc_nx[t*32 +: 32]  = ix_rollback_pc;
                sub_nx[t*4 +: 4]   = ix_subcycle;
            end else begin
                src_nx[t*2 +: 2]   = SRC_NONE;
            end
            if (en_nx[t])
                squash_cnt_nx[t] = CW'(SQUASH_CYCLES);
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rb_rollback_en       <= '0;
            rb_rollback_pc       <= '0;
            rb_rollback_subcycle <= '0;
            rb_rollback_source   <= '0;
            rb_perf_rollback     <= 1'b0;
            rb_perf_suppressed   <= 1'b0;
            // NOTE: the per-thread counter array is small register state, not a RAM, so it
            // is cleared on reset; a window must never survive a reset.
            for (int t = 0; t < NUM_THREADS; t++)
                squash_cnt[t] <= '0;
        end else begin
            rb_rollback_en       <= en_nx;
            rb_rollback_pc       <= pc_nx;
            rb_rollback_subcycle <= sub_nx;
            rb_rollback_source   <= src_nx;
            rb_perf_rollback     <= |en_nx;
            rb_perf_suppressed   <= suppressed_nx;
            for (int t = 0; t < NUM_THREADS; t++)
                squash_cnt[t] <= squash_cnt_nx[t];
        end
    end

endmodule

// File: tb/tb_rollback_controller.sv
// Self-checking bench for rollback_controller: directed test-plan scenarios plus random
// traffic compared against an edge-numbered reference model of the arbitration rules.
module tb_rollback_controller;
    localparam int NT = 4;
    localparam int SQ = 2;
    localparam int VW = NT + NT*32 + NT*4 + NT*2 + NT + 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic            wb_trap_en, dd_rollback_en, ix_rollback_en;
    logic [1:0]      wb_trap_thread_idx, dd_rollback_thread_idx, ix_thread_idx;
    logic [31:0]     wb_trap_pc, dd_rollback_pc, ix_rollback_pc;
    logic [3:0]      ix_subcycle;
    logic [NT-1:0]   rb_rollback_en, rb_squash_active;
    logic [NT*32-1:0] rb_rollback_pc;
    logic [NT*4-1:0] rb_rollback_subcycle;
    logic [NT*2-1:0] rb_rollback_source;
    logic            rb_perf_rollback, rb_perf_suppressed;

    rollback_controller #(.NUM_THREADS(NT), .SQUASH_CYCLES(SQ)) dut (
        .clk(clk), .reset(reset),
        .wb_trap_en(wb_trap_en), .wb_trap_thread_idx(wb_trap_thread_idx), .wb_trap_pc(wb_trap_pc),
        .dd_rollback_en(dd_rollback_en), .dd_rollback_thread_idx(dd_rollback_thread_idx),
        .dd_rollback_pc(dd_rollback_pc),
        .ix_rollback_en(ix_rollback_en), .ix_thread_idx(ix_thread_idx),
        .ix_rollback_pc(ix_rollback_pc), .ix_subcycle(ix_subcycle),
        .rb_rollback_en(rb_rollback_en), .rb_rollback_pc(rb_rollback_pc),
        .rb_rollback_subcycle(rb_rollback_subcycle), .rb_rollback_source(rb_rollback_source),
        .rb_squash_active(rb_squash_active), .rb_perf_rollback(rb_perf_rollback),
        .rb_perf_suppressed(rb_perf_suppressed)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: each thread remembers the edge number of its last accepted rollback.
    int          m_last [NT];
    logic [31:0] m_pc   [NT];
    logic [3:0]  m_sub  [NT];
    logic [1:0]  e_src  [NT];
    logic [NT-1:0] e_en, e_act;
    logic        e_prb, e_psup;

    function automatic logic [VW-1:0] obs_vec();
        return {rb_rollback_en, rb_rollback_pc, rb_rollback_subcycle, rb_rollback_source,
                rb_squash_active, rb_perf_rollback, rb_perf_suppressed};
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        logic [NT*32-1:0] pcs;
        logic [NT*4-1:0]  subs;
        logic [NT*2-1:0]  srcs;
        for (int t = 0; t < NT; t++) begin
            pcs[t*32 +: 32] = m_pc[t];
            subs[t*4 +: 4]  = m_sub[t];
            srcs[t*2 +: 2]  = e_src[t];
        end
        return {e_en, pcs, subs, srcs, e_act, e_prb, e_psup};
    endfunction

    task automatic model_reset();
        for (int t = 0; t < NT; t++) begin
            m_last[t] = -1000;
            m_pc[t]   = '0;
            m_sub[t]  = '0;
            e_src[t]  = '0;
        end
        e_en = '0; e_act = '0; e_prb = 1'b0; e_psup = 1'b0;
    endtask

    task automatic model_edge();
        bit tr, dd, ix, blocked, acc;
        cyc++;
        e_prb = 1'b0; e_psup = 1'b0;
        for (int t = 0; t < NT; t++) begin
            tr = wb_trap_en && (int'(wb_trap_thread_idx) == t);
            dd = dd_rollback_en && (int'(dd_rollback_thread_idx) == t);
            ix = ix_rollback_en && (int'(ix_thread_idx) == t);
            blocked = (cyc - m_last[t]) <= SQ;
            acc = 1'b1;
            if ((dd || ix) && blocked) e_psup = 1'b1;
            if (tr) begin
                e_src[t] = 2'd3; m_pc[t] = wb_trap_pc; m_sub[t] = 4'd0;
            end else if (dd && !blocked) begin
                e_src[t] = 2'd2; m_pc[t] = dd_rollback_pc; m_sub[t] = 4'd0;
            end else if (ix && !blocked) begin
                e_src[t] = 2'd1; m_pc[t] = ix_rollback_pc; m_sub[t] = ix_subcycle;
            end else begin
                e_src[t] = 2'd0; acc = 1'b0;
            end
            e_en[t] = acc;
            if (acc) begin
                m_last[t] = cyc;
                e_prb = 1'b1;
            end
            e_act[t] = (cyc - m_last[t]) < SQ;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_reset();
        else       model_edge();
        #1;
    endtask

    task automatic idle();
        wb_trap_en = 0; dd_rollback_en = 0; ix_rollback_en = 0;
        wb_trap_thread_idx = 0; dd_rollback_thread_idx = 0; ix_thread_idx = 0;
        wb_trap_pc = 0; dd_rollback_pc = 0; ix_rollback_pc = 0; ix_subcycle = 0;
    endtask

    task automatic settle(int n);
        idle();
        repeat (n) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        model_reset();
        tick(); tick();
        n_checks++;
        if (obs_vec() !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected all zero", obs_vec());
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_idle: got %h expected %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_single_ix();
        settle(4);
        ix_rollback_en = 1; ix_thread_idx = 0; ix_rollback_pc = 32'h8374_0350; ix_subcycle = 4'd2;
        tick();
        idle();
        n_checks++;
        if ({rb_rollback_en, rb_rollback_pc[31:0], rb_rollback_subcycle[3:0],
             rb_rollback_source[1:0], rb_perf_rollback, rb_squash_active[0]}
            !== {4'b0001, 32'h8374_0350, 4'd2, 2'd1, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL single_ix: en=%b pc=%h sub=%0d src=%0d perf=%b act=%b", rb_rollback_en,
                     rb_rollback_pc[31:0], rb_rollback_subcycle[3:0], rb_rollback_source[1:0],
                     rb_perf_rollback, rb_squash_active[0]);
        end
        n_checks++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL single_ix_model: got %h expected %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_collision();
        settle(4);
        wb_trap_en = 1;     wb_trap_thread_idx = 2;     wb_trap_pc = 32'h1000;
        dd_rollback_en = 1; dd_rollback_thread_idx = 2; dd_rollback_pc = 32'h2000;
        ix_rollback_en = 1; ix_thread_idx = 2;          ix_rollback_pc = 32'h3000; ix_subcycle = 4'd5;
        tick();
        idle();
        n_checks++;
        if ({rb_rollback_en, rb_rollback_pc[95:64], rb_rollback_source[5:4],
             rb_rollback_subcycle[11:8], rb_perf_suppressed}
            !== {4'b0100, 32'h1000, 2'd3, 4'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL collision: en=%b pc2=%h src2=%0d sub2=%0d sup=%b", rb_rollback_en,
                     rb_rollback_pc[95:64], rb_rollback_source[5:4], rb_rollback_subcycle[11:8],
                     rb_perf_suppressed);
        end
    endtask

    task automatic test_cross_thread();
        settle(4);
        wb_trap_en = 1;     wb_trap_thread_idx = 1;     wb_trap_pc = 32'hAAAA_0001;
        dd_rollback_en = 1; dd_rollback_thread_idx = 3; dd_rollback_pc = 32'hBBBB_0003;
        ix_rollback_en = 1; ix_thread_idx = 0;          ix_rollback_pc = 32'hCCCC_0000; ix_subcycle = 4'd7;
        tick();
        idle();
        n_checks++;
        if ({rb_rollback_en, rb_rollback_source} !== {4'b1011, 2'd2, 2'd0, 2'd3, 2'd1}) begin
            n_fail++;
            $display("FAIL cross_thread_en_src: en=%b src=%b", rb_rollback_en, rb_rollback_source);
        end
        n_checks++;
        if ({rb_rollback_pc[127:96], rb_rollback_pc[63:32], rb_rollback_pc[31:0]}
            !== {32'hBBBB_0003, 32'hAAAA_0001, 32'hCCCC_0000}) begin
            n_fail++;
            $display("FAIL cross_thread_pc: pc=%h", rb_rollback_pc);
        end
    endtask

    task automatic test_suppression();
        settle(4);
        for (int k = 0; k < 4; k++) begin
            ix_rollback_en = 1; ix_thread_idx = 0; ix_rollback_pc = 32'h4000 + 32'(k);
            ix_subcycle = 4'(k);
            tick();
            n_checks++;
            if ({rb_rollback_en[0], rb_perf_suppressed} !== ((k == 1 || k == 2) ? 2'b01 : 2'b10)) begin
                n_fail++;
                $display("FAIL suppression_step%0d: en0=%b sup=%b", k, rb_rollback_en[0],
                         rb_perf_suppressed);
            end
        end
        idle();
    endtask

    task automatic test_trap_in_window();
        settle(4);
        ix_rollback_en = 1; ix_thread_idx = 0; ix_rollback_pc = 32'h5000;
        tick();
        idle();
        wb_trap_en = 1; wb_trap_thread_idx = 0; wb_trap_pc = 32'h1234_0020;
        tick();
        idle();
        n_checks++;
        if ({rb_rollback_en[0], rb_rollback_pc[31:0], rb_rollback_source[1:0]}
            !== {1'b1, 32'h1234_0020, 2'd3}) begin
            n_fail++;
            $display("FAIL trap_in_window: en0=%b pc0=%h src0=%0d", rb_rollback_en[0],
                     rb_rollback_pc[31:0], rb_rollback_source[1:0]);
        end
        tick();
        ix_rollback_en = 1; ix_thread_idx = 0; ix_rollback_pc = 32'h6000;
        tick();
        idle();
        n_checks++;
        if ({rb_rollback_en[0], rb_perf_suppressed} !== 2'b01) begin
            n_fail++;
            $display("FAIL trap_window_restart: en0=%b sup=%b", rb_rollback_en[0], rb_perf_suppressed);
        end
    endtask

    task automatic test_reset_mid_window();
        settle(4);
        ix_rollback_en = 1; ix_thread_idx = 1; ix_rollback_pc = 32'h7000; ix_subcycle = 4'd3;
        tick();
        idle();
        reset = 1'b1;
        #1;
        model_reset();
        n_checks++;
        if (obs_vec() !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_window: got %h expected all zero", obs_vec());
        end
        tick();
        reset = 1'b0;
        ix_rollback_en = 1; ix_thread_idx = 1; ix_rollback_pc = 32'h7100; ix_subcycle = 4'd1;
        tick();
        idle();
        n_checks++;
        if ({rb_rollback_en, rb_rollback_pc[63:32], rb_rollback_source[3:2]}
            !== {4'b0010, 32'h7100, 2'd1}) begin
            n_fail++;
            $display("FAIL after_reset_accept: en=%b pc1=%h src1=%0d", rb_rollback_en,
                     rb_rollback_pc[63:32], rb_rollback_source[3:2]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            wb_trap_en             = ($urandom_range(0, 3) == 0);
            wb_trap_thread_idx     = 2'($urandom_range(0, NT-1));
            wb_trap_pc             = $urandom;
            dd_rollback_en         = ($urandom_range(0, 2) == 0);
            dd_rollback_thread_idx = 2'($urandom_range(0, NT-1));
            dd_rollback_pc         = $urandom;
            ix_rollback_en         = ($urandom_range(0, 1) == 0);
            ix_thread_idx          = 2'($urandom_range(0, NT-1));
            ix_rollback_pc         = $urandom;
            ix_subcycle            = 4'($urandom_range(0, 15));
            tick();
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random_cycle%0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_single_ix();
        test_collision();
        test_cross_thread();
        test_suppression();
        test_trap_in_window();
        test_reset_mid_window();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rollback_controller.md
# rollback_controller

Per-thread rollback arbiter between the integer execute stage, the dcache stage and the writeback trap logic. It collects rollback requests from all three sources every cycle and resolves them per hardware thread by pipeline age: oldest source wins. It registers one rollback command per thread and suppresses stale wrong-path requests from younger stages for a fixed window after each accepted rollback. Its outputs drive thread-select PC reload and pipeline squash.

## Interface
- NUM_THREADS, default `THREADS_PER_CORE (4): hardware threads per core; thread index width TW = $clog2(NUM_THREADS).
- SQUASH_CYCLES, default 2: length of the suppression window after an accepted rollback; 0 disables suppression.

- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- wb_trap_en  in  1  trap request from writeback (oldest source).
- wb_trap_thread_idx  in  TW  thread of the trap.
- wb_trap_pc  in  32  trap handler address.
- dd_rollback_en  in  1  rollback request from the dcache stage (middle source).
- dd_rollback_thread_idx  in  TW  thread of the dcache-stage request.
- dd_rollback_pc  in  32  restart PC for the dcache-stage request.
- ix_rollback_en  in  1  branch or eret rollback from integer execute (youngest source).
- ix_thread_idx  in  TW  thread of the integer-execute request.
- ix_rollback_pc  in  32  branch target or eret address.
- ix_subcycle  in  4  subcycle of the integer-execute request.
- rb_rollback_en  out  NUM_THREADS  per-thread rollback strobe.
- rb_rollback_pc  out  NUM_THREADS x 32  per-thread restart PC.
- rb_rollback_subcycle  out  NUM_THREADS x 4  per-thread restart subcycle.
- rb_rollback_source  out  NUM_THREADS x 2  winning source: 0 none, 1 ix, 2 dd, 3 trap.
- rb_squash_active  out  NUM_THREADS  thread is inside its suppression window.
- rb_perf_rollback  out  1  pulse: at least one rollback accepted.
- rb_perf_suppressed  out  1  pulse: at least one request was suppressed.

## Operation
- Per thread T, requests are gathered combinationally from each source whose en is set and whose thread_idx == T.
- Priority for T: trap > dd > ix. Exactly one winner per thread per cycle. Losing requests for the same thread are discarded silently and are not counted as suppressed.
- Different threads resolve independently. Up to three threads can roll back in the same cycle.
- Suppression: each thread has a squash counter of width $clog2(SQUASH_CYCLES+1), reset to 0.
  - While counter[T] != 0, dd and ix requests for T are ignored and raise rb_perf_suppressed.
  - Traps are never suppressed.
- On an accepted rollback for T, counter[T] loads SQUASH_CYCLES. This includes a trap arriving during an active window, which restarts the window.
- Otherwise a nonzero counter decrements by 1 per cycle. Counters saturate at 0.
- rb_squash_active[T] = (counter[T] != 0).
- Payload of the winner is registered:
  - ix: pc = ix_rollback_pc, subcycle = ix_subcycle.
  - dd and trap: subcycle = 0.
- When no rollback is accepted for T, rb_rollback_en[T] = 0 and source = 0. pc and subcycle hold their previous values.
- The block has no handshake. Requests are single-cycle strobes and are never queued.

## Timing
- Reset values: all rb_rollback_en = 0, pc = 0, subcycle = 0, source = 0, squash counters = 0, rb_squash_active = 0, both perf pulses = 0.
- Reset asserted mid-window clears all counters and outputs immediately (asynchronously).
- Latency: a request sampled at edge N is visible on rb_* after edge N. rb_rollback_en[T] is high for exactly one cycle.
- Window: for an accept at edge N, rb_squash_active[T] is high after edges N..N+SQUASH_CYCLES-1. dd/ix requests for T sampled at edges N+1..N+SQUASH_CYCLES are dropped. A request at edge N+SQUASH_CYCLES+1 is accepted.
- Perf pulses are registered with the same one-cycle latency as the rollback they describe.

## Test plan
- Single ix branch: ix_rollback_en = 1, thread 0, pc 0x83740350, subcycle 2 → next cycle rb_rollback_en = 4'b0001, pc[0] = 0x83740350, subcycle[0] = 2, source[0] = 1, rb_perf_rollback = 1, rb_squash_active[0] = 1.
- Same-thread collision: trap (pc 0x1000), dd (pc 0x2000) and ix (pc 0x3000), all for thread 2 in the same cycle → pc[2] = 0x1000, source[2] = 3, subcycle[2] = 0. Only bit 2 of rb_rollback_en is set, and rb_perf_suppressed = 0.
- Cross-thread parallel: trap on thread 1, dd on thread 3 and ix on thread 0, same cycle → rb_rollback_en = 4'b1011, each thread carries its own pc and source (3, 2, 1).
- Suppression window with SQUASH_CYCLES = 2: ix rollback on thread 0 at cycle 10, then ix requests on thread 0 at cycles 11, 12 and 13.
  - Cycles 11 and 12 are dropped: rb_perf_suppressed pulses after each, and rb_rollback_en[0] stays 0.
  - Cycle 13 is accepted.
- Trap inside a window: ix rollback on thread 0 at cycle 20, then a trap on thread 0 at cycle 21 (pc 0x12340020) → accepted with pc[0] = 0x12340020 and source 3. The window restarts, so an ix request on thread 0 at cycle 23 is suppressed.
- Reset mid-window: assert reset one cycle after an accept → all outputs and rb_squash_active return to 0 immediately. After deassert, the first ix request for that thread is accepted.
